sram_uart_dump: RTL and testbench



---
 rtl/sram_uart_dump_pkg.sv | 29 ++
 rtl/sram_uart_dump_if.sv | 36 +++
 rtl/sram_uart_dump_strobe_timer.sv | 26 ++
 rtl/sram_uart_dump.sv | 156 +++++++++++++++
 tb/tb_sram_uart_dump.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_uart_dump_pkg.sv
`default_nettype none
// =============================================================================
// sram_uart_dump_pkg : shared state encoding and timing/idle constants. Rev 1.0
// =============================================================================
package sram_uart_dump_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_RD_SETUP  = 4'd1,
      ST_RD_WAIT   = 4'd2,
      ST_RD_LATCH  = 4'd3,
      ST_TX_LOAD   = 4'd4,
      ST_TX_PULSE  = 4'd5,
      ST_TX_END    = 4'd6,
      ST_WAIT_TBRE = 4'd7,
      ST_WAIT_TSRE = 4'd8,
      ST_NEXT      = 4'd9,
      ST_DONE      = 4'd10
   } state_t;

   localparam int DEF_RD_WAIT_CYCLES = 2;
   localparam int DEF_WRN_LOW_CYCLES = 2;

   // SRAM and UART strobes are active low
   localparam logic RAM_CTRL_IDLE   = 1'b1;
   localparam logic RAM_CTRL_ACTIVE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sram_uart_dump_if.sv
`default_nettype none
// =============================================================================
// sram_uart_dump_if : host control, SRAM control and UART strobe bundle. Rev 1.0
// =============================================================================
interface sram_uart_dump_if #(
   parameter int ADDR_W = 20
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [15:0]       word_count;
   logic [ADDR_W-1:0] base_ram_addr;
   logic              base_ram_en;
   logic              base_ram_oe;
   logic              base_ram_rw;
   logic              rdn;
   logic              wrn;
   logic              tbre;
   logic              tsre;
   logic              busy;
   logic              done;
   logic [15:0]       leds;
   logic [3:0]        state;

   modport master (
      output start, start_addr, word_count, tbre, tsre,
      input  base_ram_addr, base_ram_en, base_ram_oe, base_ram_rw,
      input  rdn, wrn, busy, done, leds, state
   );

   modport slave (
      input  start, start_addr, word_count, tbre, tsre,
      output base_ram_addr, base_ram_en, base_ram_oe, base_ram_rw,
      output rdn, wrn, busy, done, leds, state
   );
endinterface
`default_nettype wire

// File: rtl/sram_uart_dump_strobe_timer.sv
`default_nettype none
// =============================================================================
// sram_uart_dump_strobe_timer : 4-bit loadable down-counter for strobe widths. Rev 1.0
// =============================================================================
module sram_uart_dump_strobe_timer (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       load,
   input  wire logic [3:0] load_val,
   output logic            expired
);
   logic [3:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign expired = (count == 4'd0);
endmodule
`default_nettype wire

// File: rtl/sram_uart_dump.sv
`default_nettype none
// =============================================================================
// sram_uart_dump : streams SRAM words out of the UART, LSB first. Rev 1.0
// =============================================================================
module sram_uart_dump
   import sram_uart_dump_pkg::*;
#(
   parameter int ADDR_W         = 20,
   parameter int RD_WAIT_CYCLES = DEF_RD_WAIT_CYCLES,
   parameter int WRN_LOW_CYCLES = DEF_WRN_LOW_CYCLES
) (
   input  wire logic       clk,
   input  wire logic       rst,
   sram_uart_dump_if.slave ctl,
   inout  wire [31:0]      base_ram_data
);
   // the timer holds N-1 so that a state waiting on it lasts exactly N cycles
   localparam logic [3:0] RD_PRELOAD = 4'(RD_WAIT_CYCLES - 1);
   localparam logic [3:0] TX_PRELOAD = 4'(WRN_LOW_CYCLES - 1);

   state_t            st;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       remaining;
   logic [1:0]        byte_idx;
   logic [31:0]       word;
   logic [15:0]       leds;
   logic              ram_en;
   logic              ram_oe;
   logic              wrn;
   logic              busy;
   logic              done;
   logic              tx_drive;
   logic              timer_load;
   logic              timer_expired;
   logic [3:0]        timer_val;

   assign timer_load = (st == ST_RD_SETUP) || (st == ST_TX_LOAD);
   assign timer_val  = (st == ST_RD_SETUP) ? RD_PRELOAD : TX_PRELOAD;

   sram_uart_dump_strobe_timer u_strobe_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (timer_expired)
   );

   assign base_ram_data = tx_drive ? {24'hzz_zzzz, word[{byte_idx, 3'b000} +: 8]}
                                   : 32'hzzzz_zzzz;

   assign ctl.base_ram_addr = addr;
   assign ctl.base_ram_en   = ram_en;
   assign ctl.base_ram_oe   = ram_oe;
   assign ctl.base_ram_rw   = RAM_CTRL_IDLE;
   assign ctl.rdn           = RAM_CTRL_IDLE;
   assign ctl.wrn           = wrn;
   assign ctl.busy          = busy;
   assign ctl.done          = done;
   assign ctl.leds          = leds;
   assign ctl.state         = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         addr      <= '0;
         remaining <= 16'd0;
         byte_idx  <= 2'd0;
         word      <= 32'd0;
         leds      <= 16'd0;
         ram_en    <= RAM_CTRL_IDLE;
         ram_oe    <= RAM_CTRL_IDLE;
         wrn       <= RAM_CTRL_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         tx_drive  <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (ctl.start) begin
                  addr      <= ctl.start_addr;
                  remaining <= ctl.word_count;
                  byte_idx  <= 2'd0;
                  busy      <= 1'b1;
                  if (ctl.word_count == 16'd0) begin
                     st   <= ST_DONE;
                     done <= 1'b1;
                  end else begin
                     st     <= ST_RD_SETUP;
                     ram_en <= RAM_CTRL_ACTIVE;
                     ram_oe <= RAM_CTRL_ACTIVE;
                  end
               end
            end
            ST_RD_SETUP: st <= ST_RD_WAIT;
            ST_RD_WAIT: begin
               if (timer_expired) st <= ST_RD_LATCH;
            end
            ST_RD_LATCH: begin
               // oe releases on the same edge the byte driver turns on, so no overlap
               word     <= base_ram_data;
               leds     <= base_ram_data[15:0];
               ram_en   <= RAM_CTRL_IDLE;
               ram_oe   <= RAM_CTRL_IDLE;
               tx_drive <= 1'b1;
               st       <= ST_TX_LOAD;
            end
            ST_TX_LOAD: begin
               wrn <= RAM_CTRL_ACTIVE;
               st  <= ST_TX_PULSE;
            end
            ST_TX_PULSE: begin
               if (timer_expired) begin
                  wrn <= RAM_CTRL_IDLE;
                  st  <= ST_TX_END;
               end
            end
            ST_TX_END: begin
               tx_drive <= 1'b0;
               st       <= ST_WAIT_TBRE;
            end
            ST_WAIT_TBRE: begin
               if (ctl.tbre) st <= ST_WAIT_TSRE;
            end
            ST_WAIT_TSRE: begin
               if (ctl.tsre) st <= ST_NEXT;
            end
            ST_NEXT: begin
               if (byte_idx != 2'd3) begin
                  byte_idx <= byte_idx + 2'd1;
                  tx_drive <= 1'b1;
                  st       <= ST_TX_LOAD;
               end else begin
                  byte_idx  <= 2'd0;
                  addr      <= addr + 1'b1;
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     st   <= ST_DONE;
                     done <= 1'b1;
                  end else begin
                     st     <= ST_RD_SETUP;
                     ram_en <= RAM_CTRL_ACTIVE;
                     ram_oe <= RAM_CTRL_ACTIVE;
                  end
               end
            end
            ST_DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               st   <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_sram_uart_dump.sv
`default_nettype none
// =============================================================================
// tb_sram_uart_dump : randomized self-checking bench with SRAM/UART models. Rev 1.0
// =============================================================================
module tb_sram_uart_dump;
   localparam int ADDR_W   = 20;
   localparam int RD_WAIT  = 2;
   localparam int WRN_LOW  = 2;
   localparam int WORD_CYC = 2 + RD_WAIT + 4 * (5 + WRN_LOW);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_uart_dump_if #(.ADDR_W(ADDR_W)) ifc ();

   wire [31:0]  base_ram_data;
   logic [31:0] mem [0:255];

   // SRAM model: drives the read word only while both en and oe are low
   assign base_ram_data = (!ifc.base_ram_en && !ifc.base_ram_oe) ? mem[ifc.base_ram_addr[7:0]]
                                                                 : 32'hzzzz_zzzz;

   sram_uart_dump #(
      .ADDR_W         (ADDR_W),
      .RD_WAIT_CYCLES (RD_WAIT),
      .WRN_LOW_CYCLES (WRN_LOW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ctl           (ifc),
      .base_ram_data (base_ram_data)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // UART / SRAM bus monitor: bytes captured on wrn falling, addresses on en falling
   logic [7:0]        got_bytes [$];
   logic [ADDR_W-1:0] got_addrs [$];
   int                done_cnt     = 0;
   int                overlap_errs = 0;

   initial begin
      logic prev_wrn;
      logic prev_en;
      prev_wrn = 1'b1;
      prev_en  = 1'b1;
      forever begin
         @(negedge clk);
         if (prev_wrn && !ifc.wrn)         got_bytes.push_back(base_ram_data[7:0]);
         if (prev_en && !ifc.base_ram_en)  got_addrs.push_back(ifc.base_ram_addr);
         if (ifc.done === 1'b1)            done_cnt++;
         if (!ifc.base_ram_oe && !ifc.wrn) overlap_errs++;
         prev_wrn = ifc.wrn;
         prev_en  = ifc.base_ram_en;
      end
   end

   logic [15:0] model_leds;

   task automatic run_xfer(input string name, input logic [ADDR_W-1:0] sa, input logic [15:0] cnt,
                           input bit restart, input bit tsre_stall, input bit tbre_jitter);
      logic [7:0]        exp_b [$];
      logic [ADDR_W-1:0] exp_a [$];
      logic [ADDR_W-1:0] a;
      logic [31:0]       w;
      int b0, a0, d0, o0, n, lat, hold, budget, nb, na;
      bit stalled, seen_done;

      for (int i = 0; i < int'(cnt); i++) begin
         a = sa + ADDR_W'(i);
         w = mem[a[7:0]];
         exp_a.push_back(a);
         for (int k = 0; k < 4; k++) exp_b.push_back(w[8*k +: 8]);
         model_leds = w[15:0];
      end

      @(negedge clk);
      b0 = got_bytes.size();
      a0 = got_addrs.size();
      d0 = done_cnt;
      o0 = overlap_errs;
      ifc.start_addr = sa;
      ifc.word_count = cnt;
      ifc.start      = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      n = 1;
      check_eq({name, " busy_after_start"}, ifc.busy, 1'b1);

      budget    = int'(cnt) * WORD_CYC * 4 + 200;
      seen_done = 0;
      stalled   = 0;
      hold      = 0;
      lat       = 0;
      while (!seen_done && n < budget) begin
         if (ifc.done === 1'b1) begin
            seen_done = 1;
            lat       = n;
         end else begin
            ifc.start = (restart && n == 10);
            if (restart && n == 10) ifc.start_addr = ~sa;
            if (tbre_jitter) ifc.tbre = ($urandom_range(0, 3) != 0);
            if (tsre_stall) begin
               if (!stalled && got_bytes.size() - b0 >= 1) begin
                  ifc.tsre = 1'b0;
                  stalled  = 1;
                  hold     = 20;
               end else if (stalled && hold > 0) begin
                  hold--;
                  if (hold == 0) begin
                     check_eq({name, " stall_state"}, ifc.state, 4'd8);
                     check_eq({name, " stall_wrn"}, ifc.wrn, 1'b1);
                     check_eq({name, " stall_bytes"}, got_bytes.size() - b0, 1);
                     ifc.tsre = 1'b1;
                  end
               end
            end
            @(negedge clk);
            n++;
         end
      end
      ifc.start = 1'b0;
      ifc.tbre  = 1'b1;
      ifc.tsre  = 1'b1;

      check_eq({name, " done_seen"}, seen_done, 1'b1);
      if (!tsre_stall && !tbre_jitter)
         check_eq({name, " done_latency"}, lat, 1 + int'(cnt) * WORD_CYC);
      @(negedge clk);
      check_eq({name, " done_one_cycle"}, ifc.done, 1'b0);
      check_eq({name, " busy_cleared"}, ifc.busy, 1'b0);
      check_eq({name, " back_to_idle"}, ifc.state, 4'd0);

      nb = got_bytes.size() - b0;
      na = got_addrs.size() - a0;
      check_eq({name, " byte_count"}, nb, exp_b.size());
      for (int i = 0; i < nb && i < exp_b.size(); i++)
         check_eq($sformatf("%s byte%0d", name, i), got_bytes[b0 + i], exp_b[i]);
      check_eq({name, " read_count"}, na, exp_a.size());
      for (int i = 0; i < na && i < exp_a.size(); i++)
         check_eq($sformatf("%s addr%0d", name, i), got_addrs[a0 + i], exp_a[i]);
      check_eq({name, " done_pulses"}, done_cnt - d0, 1);
      check_eq({name, " no_bus_overlap"}, overlap_errs - o0, 0);
      check_eq({name, " leds"}, ifc.leds, model_leds);
   endtask

   task automatic reset_midway(input logic [ADDR_W-1:0] sa);
      int b0, d0, n;
      @(negedge clk);
      b0 = got_bytes.size();
      d0 = done_cnt;
      ifc.start_addr = sa;
      ifc.word_count = 16'd2;
      ifc.start      = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      n = 0;
      while (got_bytes.size() - b0 < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("rst_mid reached_byte2", got_bytes.size() - b0, 2);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid wrn", ifc.wrn, 1'b1);
      check_eq("rst_mid en", ifc.base_ram_en, 1'b1);
      check_eq("rst_mid oe", ifc.base_ram_oe, 1'b1);
      check_eq("rst_mid busy", ifc.busy, 1'b0);
      check_eq("rst_mid done", ifc.done, 1'b0);
      check_eq("rst_mid state", ifc.state, 4'd0);
      check_eq("rst_mid leds", ifc.leds, 16'h0000);
      rst        = 1'b0;
      model_leds = 16'h0000;
      repeat (40) @(negedge clk);
      check_eq("rst_mid no_more_bytes", got_bytes.size() - b0, 2);
      check_eq("rst_mid no_done", done_cnt - d0, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      ifc.start      = 1'b0;
      ifc.start_addr = '0;
      ifc.word_count = 16'd0;
      ifc.tbre       = 1'b1;
      ifc.tsre       = 1'b1;
      model_leds     = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (3) @(negedge clk);

      check_eq("reset addr", ifc.base_ram_addr, 20'h00000);
      check_eq("reset en", ifc.base_ram_en, 1'b1);
      check_eq("reset oe", ifc.base_ram_oe, 1'b1);
      check_eq("reset rw", ifc.base_ram_rw, 1'b1);
      check_eq("reset rdn", ifc.rdn, 1'b1);
      check_eq("reset wrn", ifc.wrn, 1'b1);
      check_eq("reset busy", ifc.busy, 1'b0);
      check_eq("reset done", ifc.done, 1'b0);
      check_eq("reset leds", ifc.leds, 16'h0000);
      check_eq("reset state", ifc.state, 4'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      mem[8'h10] = 32'hDDCC_BBAA;
      run_xfer("basic", 20'h00010, 16'd1, 1'b0, 1'b0, 1'b0);
      check_eq("basic leds_literal", ifc.leds, 16'hBBAA);

      run_xfer("zero", 20'h00055, 16'd0, 1'b0, 1'b0, 1'b0);
      run_xfer("wrap", 20'hFFFFF, 16'd2, 1'b0, 1'b0, 1'b0);
      run_xfer("tsre_stall", 20'($urandom), 16'd2, 1'b0, 1'b1, 1'b0);
      reset_midway(20'($urandom));
      run_xfer("after_reset", 20'($urandom), 16'd1, 1'b0, 1'b0, 1'b0);
      run_xfer("restart", 20'($urandom), 16'd2, 1'b1, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = $urandom;
         run_xfer($sformatf("rand%0d", r), 20'($urandom), 16'($urandom_range(1, 3)),
                  1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
